line_fetch_scheduler: RTL

Prefetches framebuffer lines from external memory into a ping-pong line buffer, one line ahead of the raster, and streams pixels out in step with the video timing counters. It sits between the video timing generator (hcount/vcount/ad/nf) and the memory read port. It issues burst read requests, collects in-order read data, tracks bank validity, and flags underruns and late fetches.

---
 rtl/line_fetch_scheduler.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/line_fetch_scheduler.sv
// Line fetch scheduler: prefetches the next raster line from memory into a
// ping-pong line buffer and streams pixels out in step with the video timing.
module line_fetch_scheduler #(
    parameter int unsigned       ACTIVE_H_PIXELS = 1280,
    parameter int unsigned       ACTIVE_LINES    = 720,
    parameter int unsigned       TOTAL_LINES     = 750,
    parameter int unsigned       HCNTR_BITS      = 11,
    parameter int unsigned       VCNTR_BITS      = 10,
    parameter int unsigned       PIXEL_W         = 24,
    parameter int unsigned       BURST_LEN       = 64,
    parameter int unsigned       ADDR_W          = 32,
    parameter int unsigned       BYTES_PER_PIXEL = 4,
    parameter logic [ADDR_W-1:0] FB_BASE         = '0
) (
    input  logic                         pixel_clk_i,
    input  logic                         rst_n_i,
    input  logic [HCNTR_BITS-1:0]        hcount_i,
    input  logic [VCNTR_BITS-1:0]        vcount_i,
    input  logic                         ad_i,
    input  logic                         nf_i,
    output logic                         req_valid_o,
    input  logic                         req_ready_i,
    output logic [ADDR_W-1:0]            req_addr_o,
    output logic [$clog2(BURST_LEN):0]   req_len_o,
    input  logic                         rd_valid_i,
    input  logic [PIXEL_W-1:0]           rd_data_i,
    output logic [PIXEL_W-1:0]           pixel_o,
    output logic                         de_o,
    output logic                         underrun_o,
    output logic                         late_o,
    output logic                         frame_err_o
);

    localparam int unsigned NUM_BURSTS = ACTIVE_H_PIXELS / BURST_LEN;
    localparam int unsigned PTR_W      = $clog2(ACTIVE_H_PIXELS + 1);
    localparam int unsigned BIDX_W     = $clog2(NUM_BURSTS + 1);
    localparam int unsigned MEM_DEPTH  = 2 * ACTIVE_H_PIXELS;
    localparam int unsigned MEM_AW     = $clog2(MEM_DEPTH);
    localparam int unsigned LEN_W      = $clog2(BURST_LEN) + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic [VCNTR_BITS-1:0]   line_q, line_d;
    logic [BIDX_W-1:0]       burst_idx_q, burst_idx_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [1:0]              bank_valid_q, bank_valid_d;
    logic                    line_bad_q, line_bad_d;
    logic                    frame_err_q, frame_err_d;
    logic                    underrun_q, underrun_d;
    logic                    late_q, late_d;
    logic                    de_q, de_d;
    logic [PIXEL_W-1:0]      pixel_q, pixel_d;
    logic                    req_valid_q, req_valid_d;
    logic [ADDR_W-1:0]       req_addr_q, req_addr_d;
    logic [LEN_W-1:0]        req_len_q, req_len_d;

    logic [VCNTR_BITS-1:0]   target_c;
    logic                    trigger_c;
    logic                    vbank_c;
    logic                    in_range_c;
    logic                    bank_set_c;
    logic                    buf_we_c;
    logic [MEM_AW-1:0]       buf_waddr_c;
    logic [MEM_AW-1:0]       buf_raddr_c;
    logic [PIXEL_W-1:0]      buf_wdata_c;

    // Two banks of one line each, bank b occupies [b*ACTIVE_H_PIXELS +: ACTIVE_H_PIXELS]
    logic [PIXEL_W-1:0]      line_buf [MEM_DEPTH];

    function automatic logic [ADDR_W-1:0] burst_addr(input logic [VCNTR_BITS-1:0] line,
                                                     input logic [BIDX_W-1:0]     idx);
        return FB_BASE + (ADDR_W'(line) * ADDR_W'(ACTIVE_H_PIXELS)
                          + ADDR_W'(idx) * ADDR_W'(BURST_LEN)) * ADDR_W'(BYTES_PER_PIXEL);
    endfunction

    // Next line to fetch and the fetch trigger point (end of active part of the line)
    always_comb begin
        target_c  = (vcount_i == VCNTR_BITS'(TOTAL_LINES - 1)) ? '0 : vcount_i + VCNTR_BITS'(1);
        trigger_c = (hcount_i == HCNTR_BITS'(ACTIVE_H_PIXELS)) &&
                    (target_c < VCNTR_BITS'(ACTIVE_LINES));
    end

    // Next-state, buffer write, output path and bank bookkeeping
    always_comb begin
        state_d      = state_q;
        line_d       = line_q;
        burst_idx_d  = burst_idx_q;
        wr_ptr_d     = wr_ptr_q;
        bank_valid_d = bank_valid_q;
        line_bad_d   = line_bad_q;
        frame_err_d  = frame_err_q;
        underrun_d   = 1'b0;
        late_d       = 1'b0;
        de_d         = ad_i;
        pixel_d      = '0;
        bank_set_c   = 1'b0;
        buf_we_c     = 1'b0;
        buf_waddr_c  = '0;
        buf_wdata_c  = rd_data_i;
        buf_raddr_c  = '0;
        vbank_c      = vcount_i[0];
        in_range_c   = hcount_i < HCNTR_BITS'(ACTIVE_H_PIXELS);

        // Line start: a missing bank blanks the whole line
        if (ad_i && (hcount_i == '0)) begin
            underrun_d = !bank_valid_q[vbank_c];
            line_bad_d = !bank_valid_q[vbank_c];
        end

        if (in_range_c) begin
            buf_raddr_c = MEM_AW'(vbank_c) * MEM_AW'(ACTIVE_H_PIXELS) + MEM_AW'(hcount_i);
        end
        if (bank_valid_q[vbank_c] && in_range_c && !line_bad_d) begin
            pixel_d = line_buf[buf_raddr_c];
        end

        if (nf_i) begin
            frame_err_d = 1'b0;
        end
        if (underrun_d) begin
            frame_err_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (trigger_c) begin
                    state_d     = ST_REQ;
                    line_d      = target_c;
                    burst_idx_d = '0;
                    wr_ptr_d    = '0;
                end
            end
            ST_REQ: begin
                if (req_ready_i) begin
                    burst_idx_d = burst_idx_q + BIDX_W'(1);
                    if (burst_idx_q == BIDX_W'(NUM_BURSTS - 1)) begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (wr_ptr_q == PTR_W'(ACTIVE_H_PIXELS)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                bank_set_c = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        late_d = trigger_c && (state_q != ST_IDLE);

        // Read data may overlap the request phase; beats outside a fetch are dropped
        if (((state_q == ST_REQ) || (state_q == ST_WAIT)) && rd_valid_i &&
            (wr_ptr_q < PTR_W'(ACTIVE_H_PIXELS))) begin
            buf_we_c    = 1'b1;
            buf_waddr_c = MEM_AW'(line_q[0]) * MEM_AW'(ACTIVE_H_PIXELS) + MEM_AW'(wr_ptr_q);
            wr_ptr_d    = wr_ptr_q + PTR_W'(1);
        end

        // Release after the last displayed pixel; a completing fetch wins
        if (ad_i && (hcount_i == HCNTR_BITS'(ACTIVE_H_PIXELS - 1))) begin
            bank_valid_d[vbank_c] = 1'b0;
        end
        if (bank_set_c) begin
            bank_valid_d[line_q[0]] = 1'b1;
        end

        req_valid_d = (state_d == ST_REQ);
        req_addr_d  = req_valid_d ? burst_addr(line_d, burst_idx_d) : '0;
        req_len_d   = LEN_W'(BURST_LEN);
    end

    // State and output registers
    always_ff @(posedge pixel_clk_i) begin
        if (!rst_n_i) begin
            state_q      <= ST_IDLE;
            line_q       <= '0;
            burst_idx_q  <= '0;
            wr_ptr_q     <= '0;
            bank_valid_q <= '0;
            line_bad_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            underrun_q   <= 1'b0;
            late_q       <= 1'b0;
            de_q         <= 1'b0;
            pixel_q      <= '0;
            req_valid_q  <= 1'b0;
            req_addr_q   <= '0;
            req_len_q    <= '0;
        end else begin
            state_q      <= state_d;
            line_q       <= line_d;
            burst_idx_q  <= burst_idx_d;
            wr_ptr_q     <= wr_ptr_d;
            bank_valid_q <= bank_valid_d;
            line_bad_q   <= line_bad_d;
            frame_err_q  <= frame_err_d;
            underrun_q   <= underrun_d;
            late_q       <= late_d;
            de_q         <= de_d;
            pixel_q      <= pixel_d;
            req_valid_q  <= req_valid_d;
            req_addr_q   <= req_addr_d;
            req_len_q    <= req_len_d;
        end
    end

    // Line buffer write port
    always_ff @(posedge pixel_clk_i) begin
        if (buf_we_c) begin
            line_buf[buf_waddr_c] <= buf_wdata_c;
        end
    end

    assign req_valid_o = req_valid_q;
    assign req_addr_o  = req_addr_q;
    assign req_len_o   = req_len_q;
    assign pixel_o     = pixel_q;
    assign de_o        = de_q;
    assign underrun_o  = underrun_q;
    assign late_o      = late_q;
    assign frame_err_o = frame_err_q;

endmodule
